// File: rtl/iic_cond_gen.sv
// rtl/iic_cond_gen.sv - I2C START / repeated START / STOP condition generator
//
// Generates bus conditions for the byte-level I2C master controller using its
// own quarter-period timing. Each condition is a fixed sequence of phases, and
// every phase lasts Q = CLK_FREQ/(4*SCL_FREQ) clock cycles.
//
// Optional feature macro: IIC_CLK_STRETCH_EN
//   defined   : phases that release SCL wait at count 0 until synchronised SCL
//               reads high (slave clock stretching)
//   undefined : scl_i is unused and phases run purely on time
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd[1:0]   in   00 START, 01 RSTART, 10 STOP, 11 reserved
//   cmd_ready  out  idle, a command can be accepted
//   done       out  one-cycle pulse when a command completes
//   err        out  qualifies done: illegal command or arbitration lost
//   owned      out  this master holds the bus (START .. STOP)
//   scl_i      in   raw SCL pad level (asynchronous)
//   sda_i      in   raw SDA pad level (asynchronous)
//   scl_oe     out  1 = pull SCL low
//   sda_oe     out  1 = pull SDA low
`timescale 1ns/1ps

module iic_cond_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       done,
  output logic       err,
  output logic       owned,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int Q  = CLK_FREQ / (4 * SCL_FREQ);
  localparam int CW = (Q >= 2) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(Q - 1);

  localparam logic [1:0] CMD_START  = 2'b00;
  localparam logic [1:0] CMD_RSTART = 2'b01;
  localparam logic [1:0] CMD_STOP   = 2'b10;

  if (Q < 2) begin : g_bad_q
    $error("iic_cond_gen: CLK_FREQ/(4*SCL_FREQ) must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            owned_q, owned_d;
  logic            scl_oe_q, scl_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      sda_sync_q, sda_sync_d;

  logic            in_phase;
  logic            hold;
  logic            phase_end;
  logic            accept;
  logic            legal;

  assign cmd_ready = (state_q == IDLE) || (state_q == FIN);
  assign accept    = cmd_valid && cmd_ready;
  assign in_phase  = (state_q == PH1) || (state_q == PH2) ||
                     (state_q == PH3) || (state_q == PH4);

  // START needs a free bus (not owned); RSTART/STOP need ownership.
  assign legal = ((cmd == CMD_START) && !owned_q) ||
                 (((cmd == CMD_RSTART) || (cmd == CMD_STOP)) && owned_q);

`ifdef IIC_CLK_STRETCH_EN
  logic [1:0] scl_sync_q, scl_sync_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= scl_sync_d;
    end
  end

  // While SCL is released but still reads low, a slave is stretching the
  // clock: keep the phase parked at count 0.
  assign hold = in_phase && !scl_oe_q && !scl_sync_q[1];
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  assign phase_end = (cnt_q == CNT_LAST) && !hold;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    owned_d    = owned_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sda_sync_d = {sda_sync_q[0], sda_i};

    if (in_phase && !hold && !phase_end) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      IDLE, FIN: begin
        if (accept) begin
          cmd_d = cmd;
          if (legal) begin
            state_d = PH1;
            case (cmd)
              CMD_START: begin
                // S1: both released while the bus is checked for idle
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
              end
              CMD_RSTART: begin
                // R1: SDA released under a low SCL
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b0;
              end
              default: begin
                // P1: both low
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b1;
              end
            endcase
          end else begin
            // Illegal command: no phases, lines untouched
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end

      PH1: begin
        if (phase_end) begin
          if (cmd_q == CMD_START) begin
            if (!sda_sync_q[1]) begin
              // Someone else holds SDA: lost arbitration, stay off the bus
              state_d  = FIN;
              done_d   = 1'b1;
              err_d    = 1'b1;
              scl_oe_d = 1'b0;
              sda_oe_d = 1'b0;
            end else begin
              state_d  = PH2;
              sda_oe_d = 1'b1;   // start edge
            end
          end else begin
            state_d  = PH2;
            scl_oe_d = 1'b0;     // R2 / P2: SCL released
          end
        end
      end

      PH2: begin
        if (phase_end) begin
          state_d = PH3;
          case (cmd_q)
            CMD_START:  scl_oe_d = 1'b1;   // S3
            CMD_RSTART: sda_oe_d = 1'b1;   // R3: repeated start edge
            default:    sda_oe_d = 1'b0;   // P3: stop edge
          endcase
        end
      end

      PH3: begin
        if (phase_end) begin
          case (cmd_q)
            CMD_START: begin
              state_d = FIN;
              done_d  = 1'b1;
              owned_d = 1'b1;
            end
            CMD_RSTART: begin
              state_d  = PH4;
              scl_oe_d = 1'b1;             // R4
            end
            default: begin
              state_d = FIN;
              done_d  = 1'b1;
              owned_d = 1'b0;
            end
          endcase
        end
      end

      PH4: begin
        if (phase_end) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= CMD_START;
      owned_q    <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      owned_q    <= owned_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign owned  = owned_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_iic_cond_gen.sv
// tb/tb_iic_cond_gen.sv - scoreboard bench for iic_cond_gen
`timescale 1ns/1ps

module tb_iic_cond_gen;

  localparam int Q = 100_000_000 / (4 * 100_000);
`ifdef IIC_CLK_STRETCH_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       done;
  logic       err;
  logic       owned;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_hold;
  logic       sda_hold;
  logic       scl_pad;
  logic       sda_pad;

  assign scl_pad = ~(scl_oe | scl_hold);
  assign sda_pad = ~(sda_oe | sda_hold);

  iic_cond_gen #(.CLK_FREQ(100_000_000), .SCL_FREQ(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .done      (done),
    .err       (err),
    .owned     (owned),
    .scl_i     (scl_pad),
    .sda_i     (sda_pad),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit err;
    bit owned;
    bit scl;
    bit sda;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model state: bus ownership and the line drive it implies
  bit m_owned = 1'b0;
  bit m_scl   = 1'b0;
  bit m_sda   = 1'b0;
  int slave_ext = 0;
  int acc_cyc = 0;

  task automatic model_push(input logic [1:0] c, input int ncyc);
    exp_t e;
    int   lat;
    bit   illegal;
    illegal = (c == 2'b11) || ((c == 2'b00) && m_owned) || ((c != 2'b00) && !m_owned);
    e.err = 1'b0;
    if (illegal) begin
      lat   = 1;
      e.err = 1'b1;
    end else if (c == 2'b00) begin
      if (sda_hold) begin
        lat   = Q + 1;
        e.err = 1'b1;
        m_scl = 1'b0;
        m_sda = 1'b0;
      end else begin
        lat     = 3 * Q + 1;
        m_owned = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
      end
    end else if (c == 2'b01) begin
      lat   = 4 * Q + 1 + SX;
      m_scl = 1'b1;
      m_sda = 1'b1;
    end else begin
      lat     = 3 * Q + 1 + SX + slave_ext;
      m_owned = 1'b0;
      m_scl   = 1'b0;
      m_sda   = 1'b0;
    end
    e.cyc   = ncyc + lat;
    e.owned = m_owned;
    e.scl   = m_scl;
    e.sda   = m_sda;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the first negedge after acceptance.
  task automatic issue(input logic [1:0] c);
    int n;
    n = 0;
    cmd       = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      acc_cyc = cyc + 1;
      model_push(c, cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input bit garbage);
    int n;
    n = 0;
    while (!done && n < 8000) begin
      if (garbage) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Monitor: scoreboard pop on done, plus bus-level observations
  int  err_stray = 0;
  int  sda_falls = 0;
  int  sda_rises = 0;
  int  sim_chg   = 0;
  logic scl_p = 1'b1, sda_p = 1'b1, scl_oe_p = 1'b0, sda_oe_p = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("err", int'(err), int'(mon_e.err));
          chk("owned", int'(owned), int'(mon_e.owned));
          chk("scl_oe", int'(scl_oe), int'(mon_e.scl));
          chk("sda_oe", int'(sda_oe), int'(mon_e.sda));
        end
      end else if (err) begin
        err_stray++;
      end
    end
    if (sda_p && !sda_pad && scl_p && scl_pad) sda_falls++;
    if (!sda_p && sda_pad && scl_p && scl_pad) sda_rises++;
    if ((scl_oe != scl_oe_p) && (sda_oe != sda_oe_p)) sim_chg++;
    scl_p    = scl_pad;
    sda_p    = sda_pad;
    scl_oe_p = scl_oe;
    sda_oe_p = sda_oe;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int f0;
    int r0;
    logic [1:0] c;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    scl_hold  = 1'b0;
    sda_hold  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", int'(scl_oe), 0);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_owned", int'(owned), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // START with phase-edge timing
    issue(2'b00);
    a = acc_cyc;
    while (cyc < a + 249) @(negedge clk);
    chk("start_sda_oe_c250", int'(sda_oe), 0);
    @(negedge clk);
    chk("start_sda_oe_c251", int'(sda_oe), 1);
    while (cyc < a + 499) @(negedge clk);
    chk("start_scl_oe_c500", int'(scl_oe), 0);
    @(negedge clk);
    chk("start_scl_oe_c501", int'(scl_oe), 1);
    wait_done(1'b0);
    issue(2'b10);
    wait_done(1'b0);

    // Illegal: STOP while not owned, then reserved code
    issue(2'b10);
    wait_done(1'b0);
    issue(2'b11);
    wait_done(1'b0);

    // Back-to-back START, RSTART, STOP
    f0 = sda_falls;
    r0 = sda_rises;
    issue(2'b00);
    a = acc_cyc;
    wait_done(1'b0);
    issue(2'b01);
    wait_done(1'b0);
    issue(2'b10);
    wait_done(1'b0);
    chk("b2b_span", cyc - a + 1, 3 * Q + 4 * Q + 3 * Q + 3 + 2 * SX);
    chk("b2b_sda_falls_scl_high", sda_falls - f0, 2);
    chk("b2b_sda_rises_scl_high", sda_rises - r0, 1);
    chk("b2b_owned_end", int'(owned), 0);

    // START against a busy bus
    @(negedge clk);
    sda_hold = 1'b1;
    issue(2'b00);
    wait_done(1'b0);
    sda_hold = 1'b0;
    @(negedge clk);

    // Reset during STOP
    issue(2'b00);
    wait_done(1'b0);
    issue(2'b10);
    a = acc_cyc;
    while (cyc < a + 299) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    m_owned = 1'b0;
    m_scl   = 1'b0;
    m_sda   = 1'b0;
    #1;
    chk("midrst_scl_oe", int'(scl_oe), 0);
    chk("midrst_sda_oe", int'(sda_oe), 0);
    chk("midrst_owned", int'(owned), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_done", int'(done), 0);

`ifdef IIC_CLK_STRETCH_EN
    // Slave stretches SCL for 100 cycles from the start of P2
    issue(2'b00);
    wait_done(1'b0);
    scl_hold  = 1'b1;
    slave_ext = 100;
    issue(2'b10);
    slave_ext = 0;
    a = acc_cyc;
    while (cyc < a + Q + 100) @(negedge clk);
    scl_hold = 1'b0;
    wait_done(1'b0);
`endif

    // Randomized traffic with busy-time noise on cmd/cmd_valid
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      c = 2'($urandom_range(0, 3));
      if ((c == 2'b00) && !m_owned && ($urandom_range(0, 3) == 0)) sda_hold = 1'b1;
      issue(c);
      wait_done(1'b1);
      sda_hold = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("err_without_done", err_stray, 0);
    chk("scl_sda_same_cycle", sim_chg, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
